// File: rtl/rs_station_pkg.sv
// Shared definitions for the reservation station, also used by EX and ROB.
// Holds the default tag / data / opcode widths and the decoded opcode
// constants that travel with each instruction through the station.
package rs_station_pkg;

    localparam int RS_TAG_W = 5;
    localparam int XLEN     = 32;
    localparam int OP_W     = 6;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 6'd0,
        OP_SUB  = 6'd1,
        OP_AND  = 6'd2,
        OP_OR   = 6'd3,
        OP_XOR  = 6'd4,
        OP_SLL  = 6'd5,
        OP_SRL  = 6'd6,
        OP_SRA  = 6'd7,
        OP_SLT  = 6'd8,
        OP_LUI  = 6'd9,
        OP_JAL  = 6'd10,
        OP_JALR = 6'd11,
        OP_BEQ  = 6'd12,
        OP_BNE  = 6'd13,
        OP_LOAD = 6'd14,
        OP_STORE = 6'd15
    } opcode_e;

endpackage

// File: rtl/rs_station_if.sv
// Bus bundle between the dispatch stage, the CDB and the execution unit on
// one side (master) and the reservation station on the other (slave).
//   disp_*  : dispatch request, fields and disp_ready back-pressure
//   cdb_*   : NUM_CDB packed wakeup broadcast channels
//   iss_*   : registered issue slot with valid/ready handshake
interface rs_station_if #(
    parameter int TAG_W   = rs_station_pkg::RS_TAG_W,
    parameter int XLEN    = rs_station_pkg::XLEN,
    parameter int OP_W    = rs_station_pkg::OP_W,
    parameter int NUM_CDB = 3
);
    import rs_station_pkg::*;

    logic                    disp_valid;
    logic                    disp_ready;
    logic [OP_W-1:0]         disp_op;
    logic [XLEN-1:0]         disp_pc;
    logic [XLEN-1:0]         disp_imm;
    logic [TAG_W-1:0]        disp_rob;
    logic [XLEN-1:0]         disp_vj;
    logic [XLEN-1:0]         disp_vk;
    logic                    disp_qj_v;
    logic                    disp_qk_v;
    logic [TAG_W-1:0]        disp_qj;
    logic [TAG_W-1:0]        disp_qk;

    logic [NUM_CDB-1:0]      cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0] cdb_data;

    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [XLEN-1:0]         iss_pc;
    logic [XLEN-1:0]         iss_imm;
    logic [XLEN-1:0]         iss_vj;
    logic [XLEN-1:0]         iss_vk;
    logic [TAG_W-1:0]        iss_rob;

    modport master (
        output disp_valid, disp_op, disp_pc, disp_imm, disp_rob,
               disp_vj, disp_vk, disp_qj_v, disp_qk_v, disp_qj, disp_qk,
        input  disp_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  iss_valid, iss_op, iss_pc, iss_imm, iss_vj, iss_vk, iss_rob,
        output iss_ready
    );

    modport slave (
        input  disp_valid, disp_op, disp_pc, disp_imm, disp_rob,
               disp_vj, disp_vk, disp_qj_v, disp_qk_v, disp_qj, disp_qk,
        output disp_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output iss_valid, iss_op, iss_pc, iss_imm, iss_vj, iss_vk, iss_rob,
        input  iss_ready
    );

endinterface

// File: rtl/rs_age_matrix.sv
// DEPTH x DEPTH age matrix: older[i][j]=1 means entry i was dispatched
// before entry j. Produces a one-hot grant for the oldest ready entry.
//   clk, rst (async active-low), rdy (global enable), clear (flush)
//   alloc : one-hot entry written by dispatch this cycle
//   free  : one-hot entry released by issue this cycle
//   busy  : current occupancy
//   ready : entries eligible for issue
//   grant : one-hot oldest ready entry
module rs_age_matrix #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant
);
    import rs_station_pkg::*;

    logic [DEPTH-1:0] older [DEPTH];
    logic [DEPTH-1:0] blocked;

    // A new entry is younger than everything already resident; rows and
    // columns of released entries are wiped so stale order never leaks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (rdy) begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) older[i] <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (alloc[i] || free[i] || free[j])
                            older[i][j] <= 1'b0;
                        else if (alloc[j] && busy[i])
                            older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // An entry is blocked when any ready entry is older than it.
    always_comb begin
        blocked = '0;
        grant   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older[j][i]) blocked[i] = 1'b1;
            end
            grant[i] = ready[i] & ~blocked[i];
        end
    end

endmodule

// File: rtl/rs_station.sv
// Parametrised reservation station. Buffers dispatched instructions until
// both operands are available (woken by NUM_CDB broadcast channels) and
// issues the oldest ready entry through a registered valid/ready slot.
//   clk, rst (async active-low), rdy (global enable), clear (flush)
//   bus      : rs_station_if slave (dispatch, CDB, issue)
//   free_cnt : number of free entries
module rs_station #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = rs_station_pkg::RS_TAG_W,
    parameter int XLEN    = rs_station_pkg::XLEN,
    parameter int OP_W    = rs_station_pkg::OP_W,
    parameter int NUM_CDB = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clear,
    rs_station_if.slave              bus,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    import rs_station_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0] busy, qj_v, qk_v;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [XLEN-1:0]  pc_q  [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [TAG_W-1:0] rob_q [DEPTH];
    logic [XLEN-1:0]  vj_q  [DEPTH];
    logic [XLEN-1:0]  vk_q  [DEPTH];
    logic [TAG_W-1:0] qj_q  [DEPTH];
    logic [TAG_W-1:0] qk_q  [DEPTH];

    logic [XLEN:0]    wake_j [DEPTH];
    logic [XLEN:0]    wake_k [DEPTH];
    logic [XLEN:0]    byp_j, byp_k;

    logic [DEPTH-1:0] ready_vec, alloc, grant, free_vec;
    logic             alloc_found, disp_fire, iss_load;
    logic [IDX_W-1:0] sel_idx;

    logic             iss_valid_q;
    logic [OP_W-1:0]  iss_op_q;
    logic [XLEN-1:0]  iss_pc_q, iss_imm_q, iss_vj_q, iss_vk_q;
    logic [TAG_W-1:0] iss_rob_q;

    // Returns {hit, data}; scanning from the top down lets the lowest
    // matching channel overwrite any higher one.
    function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == tag)
                r = {1'b1, bus.cdb_data[c*XLEN +: XLEN]};
        end
        return r;
    endfunction

    always_comb begin
        byp_j = cdb_lookup(bus.disp_qj);
        byp_k = cdb_lookup(bus.disp_qk);
        for (int i = 0; i < DEPTH; i++) begin
            wake_j[i] = cdb_lookup(qj_q[i]);
            wake_k[i] = cdb_lookup(qk_q[i]);
        end
    end

    // Lowest-index free slot and free-entry popcount.
    always_comb begin
        alloc       = '0;
        alloc_found = 1'b0;
        free_cnt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !alloc_found) begin
                alloc[i]    = 1'b1;
                alloc_found = 1'b1;
            end
            free_cnt = free_cnt + CNT_W'(!busy[i]);
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel_idx = IDX_W'(i);
        end
    end

    assign bus.disp_ready = alloc_found;
    assign disp_fire      = bus.disp_valid & alloc_found;
    assign ready_vec      = busy & ~qj_v & ~qk_v;
    assign iss_load       = (!iss_valid_q || bus.iss_ready) && (|ready_vec);
    assign free_vec       = iss_load ? grant : '0;

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .alloc (disp_fire ? alloc : '0),
        .free  (free_vec),
        .busy  (busy),
        .ready (ready_vec),
        .grant (grant)
    );

    // Entry storage: wakeup, release on issue and dispatch write. A slot
    // freed by issue cannot be the dispatch target in the same cycle since
    // alloc only ever points at an entry that was not busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            qj_v <= '0;
            qk_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                pc_q[i]  <= '0;
                imm_q[i] <= '0;
                rob_q[i] <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (clear) begin
                busy <= '0;
                qj_v <= '0;
                qk_v <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i] && qj_v[i] && wake_j[i][XLEN]) begin
                        vj_q[i] <= wake_j[i][XLEN-1:0];
                        qj_v[i] <= 1'b0;
                    end
                    if (busy[i] && qk_v[i] && wake_k[i][XLEN]) begin
                        vk_q[i] <= wake_k[i][XLEN-1:0];
                        qk_v[i] <= 1'b0;
                    end
                    if (free_vec[i]) busy[i] <= 1'b0;
                    if (disp_fire && alloc[i]) begin
                        busy[i]  <= 1'b1;
                        op_q[i]  <= bus.disp_op;
                        pc_q[i]  <= bus.disp_pc;
                        imm_q[i] <= bus.disp_imm;
                        rob_q[i] <= bus.disp_rob;
                        qj_q[i]  <= bus.disp_qj;
                        qk_q[i]  <= bus.disp_qk;
                        qj_v[i]  <= bus.disp_qj_v & ~byp_j[XLEN];
                        qk_v[i]  <= bus.disp_qk_v & ~byp_k[XLEN];
                        vj_q[i]  <= (bus.disp_qj_v && byp_j[XLEN]) ? byp_j[XLEN-1:0] : bus.disp_vj;
                        vk_q[i]  <= (bus.disp_qk_v && byp_k[XLEN]) ? byp_k[XLEN-1:0] : bus.disp_vk;
                    end
                end
            end
        end
    end

    // Issue slot: refills whenever it is empty or being consumed; while
    // stalled the outputs hold and nothing is released from the station.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_pc_q    <= '0;
            iss_imm_q   <= '0;
            iss_vj_q    <= '0;
            iss_vk_q    <= '0;
            iss_rob_q   <= '0;
        end else if (rdy) begin
            if (clear) begin
                iss_valid_q <= 1'b0;
            end else if (!iss_valid_q || bus.iss_ready) begin
                iss_valid_q <= iss_load;
                if (iss_load) begin
                    iss_op_q  <= op_q[sel_idx];
                    iss_pc_q  <= pc_q[sel_idx];
                    iss_imm_q <= imm_q[sel_idx];
                    iss_vj_q  <= vj_q[sel_idx];
                    iss_vk_q  <= vk_q[sel_idx];
                    iss_rob_q <= rob_q[sel_idx];
                end
            end
        end
    end

    assign bus.iss_valid = iss_valid_q;
    assign bus.iss_op    = iss_op_q;
    assign bus.iss_pc    = iss_pc_q;
    assign bus.iss_imm   = iss_imm_q;
    assign bus.iss_vj    = iss_vj_q;
    assign bus.iss_vk    = iss_vk_q;
    assign bus.iss_rob   = iss_rob_q;

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station. A queue-based model (entries kept in
// dispatch order, so "oldest ready" is simply the first ready queue entry)
// is compared against the DUT on every falling edge; directed scenarios
// add literal expectations, then a randomized phase exercises the rest.
module tb_rs_station;

    localparam int D  = 16;
    localparam int TW = 5;
    localparam int XW = 32;
    localparam int OW = 6;
    localparam int NC = 3;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [XW-1:0] pc;
        logic [XW-1:0] imm;
        logic [TW-1:0] rob;
        logic [XW-1:0] vj;
        logic [XW-1:0] vk;
        logic          qj_v;
        logic [TW-1:0] qj;
        logic          qk_v;
        logic [TW-1:0] qk;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;
    logic [$clog2(D):0] free_cnt;
    logic check_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    ent_t mq [$];
    ent_t m_iss = '0;
    logic m_iss_valid = 1'b0;

    rs_station_if #(.TAG_W(TW), .XLEN(XW), .OP_W(OW), .NUM_CDB(NC)) bus ();

    rs_station #(.DEPTH(D), .TAG_W(TW), .XLEN(XW), .OP_W(OW), .NUM_CDB(NC)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clear    (clear),
        .bus      (bus),
        .free_cnt (free_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest channel carrying the tag supplies the value.
    function automatic logic [XW:0] model_cdb(input logic [TW-1:0] tag);
        for (int c = 0; c < NC; c++) begin
            if (bus.cdb_valid[c] && bus.cdb_tag[c*TW +: TW] == tag)
                return {1'b1, bus.cdb_data[c*XW +: XW]};
        end
        return '0;
    endfunction

    // Reference model: one step per clock edge from the dispatch-order queue.
    always @(posedge clk or negedge rst) begin : model
        ent_t e;
        int occ;
        int sel;
        logic [XW:0] w;
        if (!rst) begin
            mq.delete();
            m_iss_valid = 1'b0;
            m_iss = '0;
        end else if (rdy) begin
            if (clear) begin
                mq.delete();
                m_iss_valid = 1'b0;
            end else begin
                occ = mq.size();
                if (!m_iss_valid || bus.iss_ready) begin
                    sel = -1;
                    for (int i = 0; i < mq.size(); i++)
                        if (sel < 0 && !mq[i].qj_v && !mq[i].qk_v) sel = i;
                    if (sel >= 0) begin
                        m_iss = mq[sel];
                        m_iss_valid = 1'b1;
                        mq.delete(sel);
                    end else begin
                        m_iss_valid = 1'b0;
                    end
                end
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].qj_v) begin
                        w = model_cdb(mq[i].qj);
                        if (w[XW]) begin mq[i].vj = w[XW-1:0]; mq[i].qj_v = 1'b0; end
                    end
                    if (mq[i].qk_v) begin
                        w = model_cdb(mq[i].qk);
                        if (w[XW]) begin mq[i].vk = w[XW-1:0]; mq[i].qk_v = 1'b0; end
                    end
                end
                if (bus.disp_valid && occ < D) begin
                    e.op = bus.disp_op;   e.pc = bus.disp_pc;   e.imm = bus.disp_imm;
                    e.rob = bus.disp_rob; e.vj = bus.disp_vj;   e.vk = bus.disp_vk;
                    e.qj = bus.disp_qj;   e.qk = bus.disp_qk;
                    e.qj_v = bus.disp_qj_v; e.qk_v = bus.disp_qk_v;
                    if (e.qj_v) begin
                        w = model_cdb(e.qj);
                        if (w[XW]) begin e.vj = w[XW-1:0]; e.qj_v = 1'b0; end
                    end
                    if (e.qk_v) begin
                        w = model_cdb(e.qk);
                        if (w[XW]) begin e.vk = w[XW-1:0]; e.qk_v = 1'b0; end
                    end
                    mq.push_back(e);
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en && rst) begin
            checkOutput("iss_valid",  64'(bus.iss_valid),  64'(m_iss_valid));
            checkOutput("disp_ready", 64'(bus.disp_ready), 64'(mq.size() < D));
            checkOutput("free_cnt",   64'(free_cnt),       64'(D - mq.size()));
            checkOutput("iss_op",     64'(bus.iss_op),     64'(m_iss.op));
            checkOutput("iss_pc",     64'(bus.iss_pc),     64'(m_iss.pc));
            checkOutput("iss_imm",    64'(bus.iss_imm),    64'(m_iss.imm));
            checkOutput("iss_vj",     64'(bus.iss_vj),     64'(m_iss.vj));
            checkOutput("iss_vk",     64'(bus.iss_vk),     64'(m_iss.vk));
            checkOutput("iss_rob",    64'(bus.iss_rob),    64'(m_iss.rob));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.disp_qj_v  = 1'b0;
        bus.disp_qk_v  = 1'b0;
        bus.cdb_valid  = '0;
    endtask

    task automatic applyStimulus(input logic [TW-1:0] rob, input logic [XW-1:0] vj,
                                 input logic [XW-1:0] vk, input logic qj_v,
                                 input logic [TW-1:0] qj, input logic qk_v,
                                 input logic [TW-1:0] qk);
        bus.disp_valid = 1'b1;
        bus.disp_op    = OW'($urandom_range(63));
        bus.disp_pc    = $urandom;
        bus.disp_imm   = $urandom;
        bus.disp_rob   = rob;
        bus.disp_vj    = vj;
        bus.disp_vk    = vk;
        bus.disp_qj_v  = qj_v;
        bus.disp_qj    = qj;
        bus.disp_qk_v  = qk_v;
        bus.disp_qk    = qk;
    endtask

    task automatic setCdb(input int ch, input logic [TW-1:0] tag, input logic [XW-1:0] data);
        bus.cdb_valid[ch] = 1'b1;
        bus.cdb_tag[ch*TW +: TW] = tag;
        bus.cdb_data[ch*XW +: XW] = data;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        clear = 1'b0;
        bus.iss_ready = 1'b1;
        bus.disp_op = '0; bus.disp_pc = '0; bus.disp_imm = '0; bus.disp_rob = '0;
        bus.disp_vj = '0; bus.disp_vk = '0; bus.disp_qj = '0; bus.disp_qk = '0;
        bus.cdb_tag = '0; bus.cdb_data = '0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset iss_valid",  64'(bus.iss_valid),  64'd0);
        checkOutput("reset disp_ready", 64'(bus.disp_ready), 64'd1);
        checkOutput("reset free_cnt",   64'(free_cnt),       64'd16);
        checkOutput("reset iss_rob",    64'(bus.iss_rob),    64'd0);
        checkOutput("reset iss_vj",     64'(bus.iss_vj),     64'd0);
        rst = 1'b1;
        check_en = 1'b1;

        // Ready-operand dispatch: visible next cycle, issued the one after.
        applyStimulus(5'd3, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("s1 free_cnt N+1",  64'(free_cnt),      64'd15);
        checkOutput("s1 iss_valid N+1", 64'(bus.iss_valid), 64'd0);
        tick();
        checkOutput("s1 iss_valid N+2", 64'(bus.iss_valid), 64'd1);
        checkOutput("s1 iss_rob",       64'(bus.iss_rob),   64'd3);
        checkOutput("s1 iss_vj",        64'(bus.iss_vj),    64'd5);
        checkOutput("s1 iss_vk",        64'(bus.iss_vk),    64'd7);
        checkOutput("s1 free_cnt",      64'(free_cnt),      64'd16);

        // Waiting entry is overtaken by a younger ready one, then woken.
        applyStimulus(5'd1, 32'd0, 32'd2, 1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        applyStimulus(5'd2, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        setCdb(1, 5'd9, 32'hAA);
        tick();
        idle();
        checkOutput("s2 first iss_rob", 64'(bus.iss_rob), 64'd2);
        tick();
        checkOutput("s2 second iss_rob", 64'(bus.iss_rob), 64'd1);
        checkOutput("s2 woken iss_vj",   64'(bus.iss_vj),  64'hAA);
        tick();

        // Dispatch-time bypass from channel 0.
        applyStimulus(5'd4, 32'd1, 32'd0, 1'b0, 5'd0, 1'b1, 5'd6);
        setCdb(0, 5'd6, 32'h55);
        tick();
        idle();
        tick();
        checkOutput("s3 iss_valid", 64'(bus.iss_valid), 64'd1);
        checkOutput("s3 iss_rob",   64'(bus.iss_rob),   64'd4);
        checkOutput("s3 iss_vk",    64'(bus.iss_vk),    64'h55);
        tick();

        // Fill with the issue slot stalled; the 18th request must be ignored.
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(TW'(i), XW'(i), XW'(i + 100), 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
        end
        idle();
        checkOutput("s4 disp_ready full", 64'(bus.disp_ready), 64'd0);
        checkOutput("s4 free_cnt full",   64'(free_cnt),       64'd0);
        checkOutput("s4 held iss_rob",    64'(bus.iss_rob),    64'd0);
        tick();
        checkOutput("s4 still held",      64'(bus.iss_rob),    64'd0);
        bus.iss_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checkOutput("s4 order iss_rob", 64'(bus.iss_rob), 64'(k));
        end
        tick();
        checkOutput("s4 drained", 64'(bus.iss_valid), 64'd0);

        // Flush with a dispatch in the same cycle.
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(TW'(20 + i), 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
        end
        applyStimulus(5'd28, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        checkOutput("s5 free_cnt",  64'(free_cnt),      64'd16);
        checkOutput("s5 iss_valid", 64'(bus.iss_valid), 64'd0);
        bus.iss_ready = 1'b1;
        repeat (3) tick();
        checkOutput("s5 no issue", 64'(bus.iss_valid), 64'd0);

        // Freeze during a broadcast and a dispatch, then resume.
        applyStimulus(5'd10, 32'd0, 32'd1, 1'b1, 5'd12, 1'b0, 5'd0);
        tick();
        rdy = 1'b0;
        applyStimulus(5'd9, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        setCdb(2, 5'd12, 32'h77);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("s6 frozen free_cnt",  64'(free_cnt),      64'd15);
            checkOutput("s6 frozen iss_valid", 64'(bus.iss_valid), 64'd0);
        end
        rdy = 1'b1;
        tick();
        idle();
        checkOutput("s6 resumed free_cnt", 64'(free_cnt), 64'd14);
        tick();
        checkOutput("s6 older first", 64'(bus.iss_rob), 64'd10);
        checkOutput("s6 woken vj",    64'(bus.iss_vj),  64'h77);
        tick();
        checkOutput("s6 then rob9",   64'(bus.iss_rob), 64'd9);
        tick();

        // Asynchronous reset with a pending issue.
        bus.iss_ready = 1'b0;
        applyStimulus(5'd15, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(5'd16, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        checkOutput("s7 pre-reset iss_valid", 64'(bus.iss_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("s7 async iss_valid", 64'(bus.iss_valid), 64'd0);
        checkOutput("s7 async free_cnt",  64'(free_cnt),      64'd16);
        checkOutput("s7 async iss_rob",   64'(bus.iss_rob),   64'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        bus.iss_ready = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rdy   = ($urandom_range(9) != 0);
            clear = ($urandom_range(59) == 0);
            bus.iss_ready = ($urandom_range(2) != 0);
            idle();
            if ($urandom_range(2) != 0)
                applyStimulus(TW'($urandom_range(31)), $urandom, $urandom,
                              1'($urandom_range(1)), TW'($urandom_range(7)),
                              1'($urandom_range(1)), TW'($urandom_range(7)));
            for (int c = 0; c < NC; c++)
                if ($urandom_range(1) != 0)
                    setCdb(c, TW'($urandom_range(7)), $urandom);
            tick();
        end
        rdy = 1'b1;
        clear = 1'b0;
        idle();
        bus.iss_ready = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
